// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcode, FSM encoding,
// queue entry layout and the RISC-V J-type immediate decoder.
package ifetch_queue_pkg;

    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFQ_IDLE    = 2'd0,
        IFQ_REQ     = 2'd1,
        IFQ_WAIT    = 2'd2,
        IFQ_DISCARD = 2'd3
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: 2^DEPTH_LOG2-entry ring buffer of 64-bit {pc, instr} words with
// show-ahead head output; clear has priority over push and pop.
module ifq_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [63:0]           push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [63:0]           head_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [63:0]           mem_q [DEPTH];
    logic [63:0]           mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_push = push && (count_q != DEPTH_CNT);
        do_pop  = pop && (count_q != '0);
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // A push into a full buffer is dropped rather than overwriting the head.
            if (do_push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + 1'b1;
            end
            if (do_pop) head_d = head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign full      = (count_q == DEPTH_CNT);
    assign count     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: one-outstanding sequential fetcher feeding a small decoder queue.
// Optional static JAL redirect on push is enabled by defining JAL_PREDICT_EN.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    output logic                mem_req_valid,
    output logic [31:0]         mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [31:0]         mem_resp_data,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [31:0]         dec_pc,
    output logic [31:0]         dec_instr,
    input  logic                flush_in,
    input  logic [31:0]         flush_pc,
    output logic [DEPTH_LOG2:0] queue_count
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    ifq_state_e          state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         next_pc;
    logic                push, pop, fifo_full;
    logic [63:0]         head_data;
    logic [DEPTH_LOG2:0] count;
    ifq_entry_t          push_entry;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IFQ_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Issue is gated on count < DEPTH so the single in-flight word always has room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFQ_IDLE:
                if (!flush_in && rdy_in && (count < DEPTH_CNT)) state_d = IFQ_REQ;
            IFQ_REQ:
                if (flush_in)           state_d = mem_req_ready ? IFQ_DISCARD : IFQ_IDLE;
                else if (mem_req_ready) state_d = IFQ_WAIT;
            IFQ_WAIT:
                if (flush_in)            state_d = mem_resp_valid ? IFQ_IDLE : IFQ_DISCARD;
                else if (mem_resp_valid) state_d = IFQ_IDLE;
            IFQ_DISCARD:
                // The stale word is consumed even if another flush lands with it.
                if (mem_resp_valid) state_d = IFQ_IDLE;
            default: state_d = IFQ_IDLE;
        endcase
    end

    always_comb begin
        next_pc = fetch_pc_q + 32'd4;
`ifdef JAL_PREDICT_EN
        if (mem_resp_data[6:0] == OPC_JAL) next_pc = fetch_pc_q + jal_imm(mem_resp_data);
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush_in)  fetch_pc_d = flush_pc;
        else if (push) fetch_pc_d = next_pc;
    end

    always_comb begin
        mem_req_valid    = (state_q == IFQ_REQ);
        mem_req_addr     = fetch_pc_q;
        push             = (state_q == IFQ_WAIT) && mem_resp_valid && !flush_in;
        push_entry.pc    = fetch_pc_q;
        push_entry.instr = mem_resp_data;
        dec_valid        = (count != '0) && rdy_in && !flush_in;
        pop              = dec_valid && dec_ready;
        dec_pc           = head_data[63:32];
        dec_instr        = head_data[31:0];
        queue_count      = count;
    end

    ifq_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush_in),
        .head_data (head_data),
        .full      (fifo_full),
        .count     (count)
    );

    push_never_full: assert property (@(posedge clk_in) disable iff (!rst_in) !(push && fifo_full));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a memory model with variable ready/latency,
// a decoder-side monitor checking the pc/instr stream against a fetch reference.
module tb_ifetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc, dec_instr;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [2:0]  queue_count;

    ifetch_queue #(.DEPTH_LOG2(2), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .flush_in(flush_in), .flush_pc(flush_pc), .queue_count(queue_count)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // memory model configuration (written by main just after a posedge, read at posedge+2)
    int          rdy_pct = 100;
    int          lat_lo  = 0;
    int          lat_hi  = 0;
    bit          jal_on  = 0;
    logic [31:0] jal_addr = '0;

    // memory model state
    bit          pending = 0;
    bit          stale   = 0;
    int          lat_cnt = 0;
    logic [31:0] paddr   = '0;
    logic [31:0] resp_addr = '0;
    logic [31:0] exp_req = 32'h0;
    logic [31:0] last_acc = '0;

    // decoder-side reference
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] flush_q[$];
    int          pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (jal_on && a == jal_addr) return 32'h0100_006F;
        return {a[26:2] ^ 25'h155_AAAA, 7'h33};
    endfunction

    // Architectural next pc for the fetch stream.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
        logic signed [31:0] off;
        off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}) ;
        off = (off << 11) >>> 11;
`ifdef JAL_PREDICT_EN
        if (w[6:0] == 7'b1101111) return pc + off;
`endif
        return pc + 32'd4;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_in = 1'b1;
        flush_pc = pc;
        flush_q.push_back(pc);
    endtask

    initial begin : watchdog
        repeat (40000) @(posedge clk_in);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Memory controller model: accepts at most one request, answers after lat cycles.
    initial begin : mem_model
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (mem_resp_valid && !stale && !flush_in) exp_req = ref_next(resp_addr, mem_resp_data);
                if (mem_req_valid && mem_req_ready) begin
                    check("one_outstanding", {31'b0, pending | mem_resp_valid}, 32'h0);
                    check("req_addr", mem_req_addr, exp_req);
                    pending  = 1;
                    stale    = 0;
                    paddr    = mem_req_addr;
                    last_acc = mem_req_addr;
                    lat_cnt  = $urandom_range(lat_hi, lat_lo);
                end
                if (flush_in) begin
                    exp_req = flush_pc;
                    if (pending) stale = 1;
                end
            end
            @(posedge clk_in); #2;
            mem_resp_valid = 1'b0;
            if (pending) begin
                if (lat_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memfn(paddr);
                    resp_addr      = paddr;
                    pending        = 0;
                end else lat_cnt--;
            end
            mem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        end
    end

    // Decoder-side monitor and protocol checks, sampled mid-cycle.
    initial begin : monitor
        bit          prev_stall = 0, prev_valid = 0, prev_rdy = 0, prev_flush = 0, post_flush = 0;
        logic [31:0] prev_addr = '0;
        logic [2:0]  prev_cnt = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (post_flush) check("count_after_flush", {29'b0, queue_count}, 32'h0);
                check("count_bound", {31'b0, queue_count <= 3'd4}, 32'h1);
                check("dec_valid_rule", {31'b0, dec_valid},
                      {31'b0, (queue_count != 0) && rdy_in && !flush_in});
                if (mem_req_valid) check("req_align", {30'b0, mem_req_addr[1:0]}, 32'h0);
                if (prev_stall) begin
                    check("req_hold_valid", {31'b0, mem_req_valid}, 32'h1);
                    check("req_hold_addr", mem_req_addr, prev_addr);
                end
                if (mem_req_valid && !prev_valid)
                    check("issue_allowed", {31'b0, prev_rdy && !prev_flush && (prev_cnt < 3'd4)}, 32'h1);
                if (flush_in) begin
                    if (flush_q.size() == 0) begin
                        errors++;
                        $display("FAIL flush_q: got empty expected entry");
                    end else exp_pc = flush_q.pop_front();
                end else if (dec_valid && dec_ready) begin
                    check("dec_pc", dec_pc, exp_pc);
                    check("dec_instr", dec_instr, memfn(exp_pc));
                    exp_pc = ref_next(exp_pc, memfn(exp_pc));
                    pops++;
                end
                post_flush = flush_in;
                prev_stall = mem_req_valid && !mem_req_ready && !flush_in;
                prev_valid = mem_req_valid;
                prev_addr  = mem_req_addr;
                prev_rdy   = rdy_in;
                prev_flush = flush_in;
                prev_cnt   = queue_count;
            end
        end
    end

    initial begin : main
        bit got;
        // reset state
        cyc(3);
        @(negedge clk_in);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_count", {29'b0, queue_count}, 32'h0);

        // release with ideal memory: first entry visible three cycles later
        @(posedge clk_in); #1;
        rst_in = 1'b1; rdy_in = 1'b1; dec_ready = 1'b1;
        @(posedge clk_in); @(posedge clk_in); @(negedge clk_in);
        check("latency_early", {31'b0, dec_valid}, 32'h0);
        @(posedge clk_in); @(negedge clk_in);
        check("latency3_valid", {31'b0, dec_valid}, 32'h1);
        check("latency3_pc", dec_pc, 32'h0);
        cyc(30);

        // back-pressure: queue saturates, no further issue
        dec_ready = 1'b0;
        cyc(20);
        @(negedge clk_in);
        check("sat_count", {29'b0, queue_count}, 32'h4);
        check("sat_req_valid", {31'b0, mem_req_valid}, 32'h0);
        @(posedge clk_in); #1;
        dec_ready = 1'b1;
        got = 0;
        repeat (6) begin @(negedge clk_in); if (mem_req_valid) got = 1; end
        check("refill_issue", {31'b0, got}, 32'h1);
        cyc(10);

        // flush while waiting for a 2-cycle response
        lat_lo = 2; lat_hi = 2;
        got = 0;
        repeat (20) begin @(negedge clk_in); if (!got && mem_req_valid && mem_req_ready) got = 1; end
        got = 0;
        repeat (20) if (!got) begin @(negedge clk_in); if (mem_req_valid && mem_req_ready) got = 1; end
        check("wait_accept", {31'b0, got}, 32'h1);
        @(posedge clk_in); #1;
        do_flush(32'h100);
        cyc(1);
        flush_in = 1'b0;
        cyc(15);
        lat_lo = 0; lat_hi = 0;

        // memory stall, then flush withdraws the held request
        rdy_pct = 0;
        got = 0;
        repeat (20) if (!got) begin @(negedge clk_in); if (mem_req_valid) got = 1; end
        check("stall_req", {31'b0, got}, 32'h1);
        cyc(5);
        do_flush(32'h400);
        cyc(1);
        flush_in = 1'b0;
        rdy_pct = 100;
        cyc(15);

        // rdy_in pause while a response comes back
        lat_lo = 1; lat_hi = 1;
        got = 0;
        repeat (20) if (!got) begin @(negedge clk_in); if (mem_req_valid && mem_req_ready) got = 1; end
        check("pause_accept", {31'b0, got}, 32'h1);
        @(posedge clk_in); #1;
        rdy_in = 1'b0;
        cyc(3);
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("pause_visible", {31'b0, dec_valid}, 32'h1);
        cyc(10);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) begin
                rdy_pct = $urandom_range(100, 40);
                lat_lo  = 0;
                lat_hi  = $urandom_range(3, 0);
            end
            dec_ready = ($urandom_range(3, 0) != 0);
            rdy_in    = ($urandom_range(9, 0) != 0);
            flush_in  = 1'b0;
            if ($urandom_range(49, 0) == 0) begin
                if ($urandom_range(3, 0) == 0) do_flush(32'hFFFF_FFF0 + {$urandom_range(3, 0), 2'b00});
                else do_flush({$urandom, 2'b00});
            end
            cyc(1);
        end
        flush_in = 1'b0; rdy_in = 1'b1; dec_ready = 1'b1; rdy_pct = 100; lat_lo = 0; lat_hi = 0;
        cyc(20);
        check("progress", {31'b0, pops >= 150}, 32'h1);

        // JAL word at 0x200: next request target depends on prediction
        jal_addr = 32'h200; jal_on = 1;
        do_flush(32'h200);
        cyc(1);
        flush_in = 1'b0;
        got = 0;
        repeat (30) if (!got) begin @(negedge clk_in); if (mem_req_valid && mem_req_ready && mem_req_addr == 32'h200) got = 1; end
        check("jal_fetch", {31'b0, got}, 32'h1);
        got = 0;
        repeat (30) if (!got) begin @(negedge clk_in); if (mem_req_valid && mem_req_ready) got = 1; end
`ifdef JAL_PREDICT_EN
        check("jal_next_addr", mem_req_addr, 32'h10 + 32'h200);
`else
        check("jal_next_addr", mem_req_addr, 32'h204);
`endif
        cyc(20);
        check("flush_q_drained", flush_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
